render_scheduler: RTL and testbench

//   Sequences the rasterization datapath for one frame: steps the object buffer
//   one object at a time, broadcasts it to all UNITS rasterizers, waits for

---
 rtl/render_scheduler.sv | 141 ++++++++++++++
 tb/tb_render_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/render_scheduler.sv
// Frame sequencer for the rasterization datapath: hands objects one at a time to
// the rasterizer array, waits for all units and the depth comparator, then fetches the next.
module render_scheduler #(
    parameter int UNITS          = 16,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             next_frame,
    input  logic             read_end,
    input  logic [UNITS-1:0] task_complete,
    input  logic             dc_all_complete,
    output logic             next_object,
    output logic             tasks_complete,
    output logic             busy,
    output logic [CNT_W-1:0] object_count,
    output logic [CNT_W-1:0] frame_count,
    output logic             timeout_error,
    output logic             overrun_error
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LAST     = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LAUNCH = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic             frame_start;
    logic             frame_empty;
    logic             launch;
    logic             obj_done;
    logic             wd_fire;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A normal completion takes priority over the watchdog in the same cycle.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_empty = 1'b0;
        launch      = 1'b0;
        obj_done    = 1'b0;
        wd_fire     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (next_frame) begin
                    state_nxt   = FETCH;
                    frame_start = 1'b1;
                end
            end
            FETCH: begin
                if (read_end) begin
                    state_nxt   = DONE;
                    frame_empty = 1'b1;
                end else begin
                    state_nxt = LAUNCH;
                    launch    = 1'b1;
                end
            end
            LAUNCH: begin
                if (settle_cnt == SETTLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (&task_complete) begin
                    state_nxt = DRAIN;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt = FETCH;
                    wd_fire   = 1'b1;
                end
            end
            DRAIN: begin
                if (dc_all_complete) begin
                    state_nxt = FETCH;
                    obj_done  = 1'b1;
                end else if (wd_cnt == WD_LAST) begin
                    state_nxt = FETCH;
                    wd_fire   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == FETCH) || (state == LAUNCH) || (state == RUN) || (state == DRAIN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_cnt     <= '0;
            wd_cnt         <= '0;
            next_object    <= 1'b0;
            tasks_complete <= 1'b0;
            object_count   <= '0;
            frame_count    <= '0;
            timeout_error  <= 1'b0;
            overrun_error  <= 1'b0;
        end else begin
            settle_cnt  <= (state == LAUNCH) ? settle_cnt + SET_W'(1) : '0;
            wd_cnt      <= (state == RUN || state == DRAIN) ? wd_cnt + WD_W'(1) : '0;
            next_object <= launch;

            if (frame_start) begin
                tasks_complete <= 1'b0;
            end else if (frame_empty) begin
                tasks_complete <= 1'b1;
            end

            if (frame_start) begin
                frame_count  <= frame_count + CNT_W'(1);
                object_count <= '0;
            end else if (obj_done && (object_count != {CNT_W{1'b1}})) begin
                object_count <= object_count + CNT_W'(1);
            end

            if (wd_fire) timeout_error <= 1'b1;
            if (busy && next_frame) overrun_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Randomized bench for render_scheduler: a small environment plays the rasterizers and
// depth comparator, and the expected pulse timing is computed from the sequencing rules.
module tb_render_scheduler;

    localparam int UNITS = 16;
    localparam int S     = 2;
    localparam int T     = 16;
    localparam int CW    = 4;
    localparam int OMAX  = (1 << CW) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             next_frame;
    logic             read_end;
    logic [UNITS-1:0] task_complete;
    logic             dc_all_complete;
    logic             next_object;
    logic             tasks_complete;
    logic             busy;
    logic [CW-1:0]    object_count;
    logic [CW-1:0]    frame_count;
    logic             timeout_error;
    logic             overrun_error;

    int total = 0;
    int bad   = 0;
    int exp_fc = 0;
    bit exp_to = 1'b0;
    bit exp_ov = 1'b0;

    render_scheduler #(
        .UNITS(UNITS), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .next_frame(next_frame), .read_end(read_end),
        .task_complete(task_complete), .dc_all_complete(dc_all_complete),
        .next_object(next_object), .tasks_complete(tasks_complete), .busy(busy),
        .object_count(object_count), .frame_count(frame_count),
        .timeout_error(timeout_error), .overrun_error(overrun_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic idle_cycles(input int n);
        int np;
        int nb;
        np = 0;
        nb = 0;
        for (int i = 0; i < n; i++) begin
            read_end        = 1'($urandom);
            task_complete   = UNITS'($urandom);
            dc_all_complete = 1'($urandom);
            @(negedge clock);
            if (next_object) np++;
            if (busy) nb++;
        end
        chk("idle_pulses", np, 0);
        chk("idle_busy", nb, 0);
    endtask

    // Offsets are counted from the cycle next_object is high (first LAUNCH cycle).
    // Units finish at offset u, comparator drains at u+d; exit offset xo is the cycle
    // the scheduler leaves RUN/DRAIN, and the next pulse or DONE lands at xo+2.
    task automatic run_frame(input int nobj, input int umin, input int umax, input int dmin,
                             input int dmax, input int stuck_idx, input int inj, input int rst_off);
        int left, pulses, counted, t0, u, d, xo, off, budget, c;
        bit stk, done;
        left = nobj; pulses = 0; counted = 0; t0 = -1; u = 0; d = 0; xo = 0;
        stk = 1'b0; done = 1'b0; off = 0;
        budget = 40 * (nobj + 1) + 10;
        read_end   = (nobj == 0);
        next_frame = 1'b1;
        @(negedge clock);
        next_frame = 1'b0;
        exp_fc = (exp_fc + 1) % (1 << CW);
        chk("start_busy", 32'(busy), 1);
        chk("start_tasks_complete", 32'(tasks_complete), 0);
        chk("start_object_count", 32'(object_count), 0);
        chk("start_frame_count", 32'(frame_count), exp_fc);
        for (int k = 0; k < budget && !done; k++) begin
            if (k > 0) @(negedge clock);
            next_frame = 1'b0;
            if (next_object) begin
                if (t0 < 0) chk("first_pulse_latency", k, 1);
                else        chk("pulse_spacing", k - t0, xo + 2);
                pulses++;
                left--;
                read_end = (left <= 0);
                t0  = k;
                u   = $urandom_range(umax, umin);
                d   = $urandom_range(dmax, dmin);
                stk = ((pulses - 1) == stuck_idx);
                c   = imax(imax(S, u) + 1, u + d);
                if (stk || (c - S + 1) > T) begin
                    xo = S + T - 1;
                    exp_to = 1'b1;
                end else begin
                    xo = c;
                    counted++;
                end
            end
            if (tasks_complete) begin
                done = 1'b1;
                if (t0 < 0) chk("empty_done_latency", k, 1);
                else        chk("done_latency", k - t0, xo + 2);
            end else begin
                off = k - t0;
                if (t0 < 0) begin
                    task_complete   = UNITS'($urandom);
                    dc_all_complete = 1'($urandom);
                end else begin
                    if (stk) begin
                        task_complete    = UNITS'($urandom);
                        task_complete[7] = 1'b0;
                    end else if (off >= u) begin
                        task_complete = '1;
                    end else begin
                        task_complete = UNITS'($urandom);
                        task_complete[$urandom_range(UNITS - 1, 0)] = 1'b0;
                    end
                    if (stk || off < imax(S, u) + 1) dc_all_complete = 1'($urandom);
                    else                            dc_all_complete = (off >= u + d);
                    if (pulses == 1 && inj == 1 && off == S) begin
                        next_frame = 1'b1;
                        exp_ov = 1'b1;
                    end
                    if (pulses == 1 && inj == 2 && off == xo) begin
                        next_frame = 1'b1;
                        exp_ov = 1'b1;
                    end
                    if (rst_off >= 0 && off == rst_off) begin
                        chk("pre_reset_busy", 32'(busy), 1);
                        #2 reset = 1'b1;
                        #1;
                        chk("async_reset_outputs", 32'({next_object, tasks_complete, busy, object_count,
                                                        frame_count, timeout_error, overrun_error}), 0);
                        exp_fc = 0;
                        exp_to = 1'b0;
                        exp_ov = 1'b0;
                        return;
                    end
                end
            end
        end
        chk("frame_reached_done", 32'(done), 1);
        chk("pulse_count", pulses, nobj);
        chk("object_count", 32'(object_count), (counted > OMAX) ? OMAX : counted);
        chk("frame_count", 32'(frame_count), exp_fc);
        chk("done_busy", 32'(busy), 0);
        chk("done_next_object", 32'(next_object), 0);
        chk("timeout_error", 32'(timeout_error), 32'(exp_to));
        chk("overrun_error", 32'(overrun_error), 32'(exp_ov));
    endtask

    initial begin
        reset           = 1'b1;
        next_frame      = 1'b0;
        read_end        = 1'b0;
        task_complete   = '0;
        dc_all_complete = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({next_object, tasks_complete, busy, object_count,
                                  frame_count, timeout_error, overrun_error}), 0);
        reset = 1'b0;
        idle_cycles(10);

        run_frame(0, 0, 0, 0, 0, -1, 0, -1);          // empty frame
        run_frame(3, 5, 5, 2, 2, -1, 0, -1);          // three objects, fixed latencies
        run_frame(4, 0, 1, 0, 2, -1, 0, -1);          // units already idle during LAUNCH
        repeat (3) run_frame($urandom_range(5, 1), 0, 8, 0, 4, -1, 0, -1);
        run_frame(3, 0, 8, 0, 4, 1, 0, -1);           // unit 7 stuck on the second object
        run_frame(4, 14, 18, 0, 1, -1, 0, -1);        // around the watchdog limit
        run_frame(3, 3, 6, 1, 3, -1, 1, -1);          // next_frame during RUN
        run_frame(2, 0, 4, 0, 3, -1, 0, -1);          // restart from DONE
        run_frame(2, 2, 4, 1, 3, -1, 2, -1);          // next_frame on DRAIN completion
        run_frame(17, 0, 1, 0, 1, -1, 0, -1);         // object_count saturation
        repeat (14) run_frame(0, 0, 0, 0, 0, -1, 0, -1);  // frame_count wrap

        run_frame(2, 2, 2, 6, 6, -1, 0, 5);           // reset in the middle of DRAIN
        @(negedge clock);
        reset = 1'b0;
        idle_cycles(20);
        run_frame(2, 0, 8, 0, 4, -1, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
